// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore-style sequencer for a multicycle RV32I-like
// datapath sharing one memory for instructions and data. Memory accesses
// (FETCH/MEMREAD/MEMWRITE) stretch until memReady; a stalled access halts the
// core with a sticky fault after WAIT_TIMEOUT idle cycles.
// Optional macro BRANCH_FULL_EN: adds blt/bge/bltu/bgeu; without it only
// beq/bne are legal and any other branch funct3 halts with fault.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W   = 4,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  negative,
  input  logic                  carry,
  input  logic                  overflow,
  input  logic                  memReady,
  output logic                  memRead,
  output logic                  memWrite,
  output logic                  irWrite,
  output logic                  pcWrite,
  output logic                  regWrite,
  output logic                  adrSrc,
  output logic [1:0]            resultSrc,
  output logic [1:0]            aluSrcA,
  output logic [1:0]            aluSrcB,
  output logic [2:0]            immSrc,
  output logic [ALU_CTRL_W-1:0] aluControl,
  output logic                  fault,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_EXECU = 4'd9, S_BRANCH = 4'd10, S_JAL = 4'd11,
    S_JALR = 4'd12, S_HALT = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011, OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011, OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // ALU source / result / immediate select encodings
  localparam logic [1:0] SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_RS1 = 2'd2, SRCA_ZERO = 2'd3;
  localparam logic [1:0] SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2;
  localparam logic [1:0] RES_ALUOUT = 2'd0, RES_RDATA = 2'd1, RES_ALU = 2'd2, RES_TARGET = 2'd3;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0), ALU_SUB  = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(2), ALU_SLT  = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(4), ALU_XOR  = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(6), ALU_SRA  = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(8), ALU_AND  = ALU_CTRL_W'(9);

  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       fault_q, fault_d;
  logic       stall;
  logic       br_legal, br_cond;

  // ALU operation for register and immediate arithmetic; alt selects SUB/SRA
  function automatic logic [ALU_CTRL_W-1:0] alu_decode(input logic [2:0] f3, input logic alt);
    logic [ALU_CTRL_W-1:0] c;
    case (f3)
      3'b000:  c = alt ? ALU_SUB : ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = alt ? ALU_SRA : ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

  // Flag condition for every branch type; legality is decided separately so
  // the reduced build simply never lets the unsigned/signed compares through.
  always_comb begin
    case (funct3)
      3'b000:  br_cond = zero;
      3'b001:  br_cond = ~zero;
      3'b100:  br_cond = negative ^ overflow;
      3'b101:  br_cond = ~(negative ^ overflow);
      3'b110:  br_cond = ~carry;
      3'b111:  br_cond = carry;
      default: br_cond = 1'b0;
    endcase
`ifdef BRANCH_FULL_EN
    br_legal = (funct3[2:1] != 2'b01);
`else
    br_legal = (funct3[2:1] == 2'b00);
`endif
  end

  // State, wait counter and sticky fault registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // Next-state and strobe decode from state, plus memReady / branch outcome
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    fault_d    = fault_q;
    stall      = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    regWrite   = 1'b0;
    adrSrc     = 1'b0;
    resultSrc  = RES_ALUOUT;
    aluSrcA    = SRCA_PC;
    aluSrcB    = SRCB_RS2;
    immSrc     = IMM_I;
    aluControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        if (memReady) begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          aluSrcA   = SRCA_PC;
          aluSrcB   = SRCB_FOUR;
          resultSrc = RES_ALU;
          state_d   = S_DECODE;
        end else begin
          stall = 1'b1;
        end
      end
      S_DECODE: begin
        // precompute the branch/jal target into the target register
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        immSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_LUI, OP_AUIPC:  state_d = S_EXECU;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        immSrc  = op[5] ? IMM_S : IMM_I;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrSrc  = 1'b1;
        memRead = 1'b1;
        if (memReady) state_d = S_MEMWB;
        else          stall   = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
        if (memReady) state_d = S_FETCH;
        else          stall   = 1'b1;
      end
      S_MEMWB: begin
        resultSrc = RES_RDATA;
        regWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECR: begin
        aluSrcA    = SRCA_RS1;
        aluSrcB    = SRCB_RS2;
        aluControl = alu_decode(funct3, funct7b5);
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        // instr[30] is immediate data except for the shift-right pair
        aluSrcA    = SRCA_RS1;
        aluSrcB    = SRCB_IMM;
        immSrc     = IMM_I;
        aluControl = alu_decode(funct3, funct7b5 & (funct3 == 3'b101));
        state_d    = S_ALUWB;
      end
      S_EXECU: begin
        // op[5] distinguishes LUI (0 + imm) from AUIPC (oldPC + imm)
        aluSrcA = op[5] ? SRCA_ZERO : SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        immSrc  = IMM_U;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        resultSrc = RES_ALUOUT;
        regWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA    = SRCA_RS1;
        aluSrcB    = SRCB_RS2;
        aluControl = ALU_SUB;
        resultSrc  = RES_TARGET;
        pcWrite    = br_legal & br_cond;
        state_d    = br_legal ? S_FETCH : S_HALT;
      end
      S_JAL: begin
        // PC takes the DECODE target while the ALU forms the link oldPC+4
        pcWrite   = 1'b1;
        resultSrc = RES_TARGET;
        aluSrcA   = SRCA_OLDPC;
        aluSrcB   = SRCB_FOUR;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        // rs1+imm goes to the PC through the ALU path; the PC input clears bit 0
        pcWrite   = 1'b1;
        resultSrc = RES_ALU;
        aluSrcA   = SRCA_RS1;
        aluSrcB   = SRCB_IMM;
        immSrc    = IMM_I;
        state_d   = S_ALUWB;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // wait counter: counts idle memory cycles, cleared on every state change
    if (stall) begin
      wait_d = wait_q + 8'd1;
      if (wait_d == WAIT_LIMIT) state_d = S_HALT;
    end
    if (state_d != state_q) wait_d = 8'd0;
    if (state_d == S_HALT) fault_d = 1'b1;

    // reset asynchronously silences every strobe and select
    if (!rst_n) begin
      memRead    = 1'b0;
      memWrite   = 1'b0;
      irWrite    = 1'b0;
      pcWrite    = 1'b0;
      regWrite   = 1'b0;
      adrSrc     = 1'b0;
      resultSrc  = 2'd0;
      aluSrcA    = 2'd0;
      aluSrcB    = 2'd0;
      immSrc     = 3'd0;
      aluControl = '0;
    end
  end

  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter ALU_CTRL_W, default 4, width of aluControl; SHALL be >=4.
REQ-002 Parameter WAIT_TIMEOUT, default 15, maximum memReady wait cycles per access; SHALL be 1..255.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 op  in  7  opcode of the instruction register; funct3  in  3; funct7b5  in  1  instr[30].
REQ-006 zero, negative, carry, overflow  in  1 each  ALU flags of the current ALU result.
REQ-007 memReady  in  1  unified memory completes the current access this cycle.
REQ-008 memRead, memWrite, irWrite, pcWrite, regWrite, adrSrc  out  1 each  datapath strobes/selects.
REQ-009 resultSrc, aluSrcA, aluSrcB  out  2 each; immSrc  out  3; aluControl  out  ALU_CTRL_W.
REQ-010 fault  out  1  sticky error; state  out  4  current FSM state for debug.

Function
REQ-011 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, EXECU, BRANCH, JAL, JALR, HALT.
REQ-012 FETCH: memRead=1, adrSrc=0; on memReady, irWrite=1, pcWrite=1, aluSrcA=PC, aluSrcB=4, ADD, resultSrc=2 (ALU), next DECODE; otherwise stays in FETCH with irWrite=pcWrite=0.
REQ-013 DECODE: aluSrcA=oldPC, aluSrcB=imm, ADD (target precompute); next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 0110111/0010111->EXECU, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, any other->HALT with fault set.
REQ-014 MEMADR: rs1+imm (immSrc I for load, S for store); next MEMREAD if op[5]=0, else MEMWRITE.
REQ-015 MEMREAD/MEMWRITE: adrSrc=1 and memRead/memWrite held high until memReady; on memReady next MEMWB/FETCH respectively.
REQ-016 MEMWB: resultSrc=1 (read data), regWrite=1, next FETCH.
REQ-017 EXECR/EXECI: aluControl from funct3/funct7b5 (funct7b5 honoured for EXECI only when funct3=101); next ALUWB; ALUWB: resultSrc=0, regWrite=1, next FETCH.
REQ-018 EXECU: LUI selects A=zero, AUIPC A=oldPC, B=imm (immSrc U), ADD; next ALUWB.
REQ-019 JAL: pcWrite=1 from DECODE target, aluSrcA=oldPC, B=4, regWrite deferred to ALUWB; JALR: pcWrite=1 with rs1+imm, LSB forced 0, next ALUWB writing oldPC+4.
REQ-020 BRANCH: SUB rs1-rs2, pcWrite=taken, resultSrc=3 (target register); next FETCH regardless of outcome.
REQ-021 Every state other than FETCH/MEMREAD/MEMWRITE SHALL last exactly one cycle.
REQ-022 An 8-bit wait counter SHALL clear on entering any memory state and increment each cycle memReady=0; reaching WAIT_TIMEOUT SHALL enter HALT with fault=1.
REQ-023 HALT: all strobes 0, fault held 1, no exit except reset.
REQ-024 Strobes SHALL be decoded from state (Moore) plus memReady/branch-taken only; no combinational path from op to memWrite or regWrite.
REQ-025 memReady asserted with zero wait SHALL complete in one cycle; memReady asserted outside memory/fetch states SHALL be ignored.

Reset
REQ-026 rst_n low SHALL immediately force state=FETCH, wait counter=0, fault=0, all strobes 0, selects 0.
REQ-027 Reset deassertion SHALL start a fetch on the first following clk edge; reset mid-access SHALL abandon the access without writes.

Configuration
REQ-028 Macro BRANCH_FULL_EN defined: BRANCH SHALL decode beq, bne, blt (N^V), bge, bltu (!C), bgeu (C) from funct3.
REQ-029 BRANCH_FULL_EN undefined: only beq/bne decode; funct3 in {100,101,110,111} SHALL enter HALT with fault=1.

Verification
REQ-030 add x3,x1,x2 with memReady always 1 -> FETCH,DECODE,EXECR,ALUWB,FETCH; regWrite=1 only in ALUWB; 4 cycles.
REQ-031 lw with memReady low 3 cycles on data read -> MEMREAD held 4 cycles, memRead=1 throughout, MEMWB regWrite=1 once.
REQ-032 blt taken (N=1,V=0) with BRANCH_FULL_EN -> pcWrite=1 in BRANCH; without macro -> HALT, fault=1.
REQ-033 memReady stuck 0 in MEMWRITE, WAIT_TIMEOUT=15 -> HALT after 15 cycles, memWrite drops to 0, fault=1.
REQ-034 op=0000000 -> DECODE then HALT, fault=1; rst_n pulse low -> state=FETCH, fault=0 without clk edge.
